// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin / fixed-priority arbiter sharing one FIFO push port,
// with a reservation level so a push is never issued into a full FIFO.
module fifo_push_arbiter #(
    parameter int fifo_w    = 32,
    parameter int fifo_d    = 8,
    parameter int n_req     = 4,
    parameter int af_thresh = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mode,
    input  logic [n_req-1:0]                  req,
    input  logic [n_req*fifo_w-1:0]           req_data,
    output logic [n_req-1:0]                  gnt,
    output logic                              push_en,
    output logic [fifo_w-1:0]                 fifo_din,
    input  logic                              rd_req,
    output logic                              pop_en,
    input  logic                              fifo_full,
    input  logic                              fifo_empty,
    output logic [$clog2(fifo_d+1)-1:0]       level,
    output logic                              almost_full,
    output logic                              ovf_err
);
    localparam int lw = $clog2(fifo_d + 1);
    localparam int pw = $clog2(n_req);
    logic [pw-1:0]    ptr, lo_win, hi_win, win;
    logic             hi_found, grant;
    logic [n_req-1:0] elig, onehot;
    logic [lw-1:0]    level_nxt;
    assign elig   = req & ~gnt;
    assign pop_en = rd_req & ~fifo_empty;
    assign grant  = |elig && level < lw'(fifo_d);
    // Descending scan keeps the lowest match: lo_win overall, hi_win above the pointer.
    always_comb begin
        lo_win   = '0;
        hi_win   = '0;
        hi_found = 1'b0;
        for (int k = n_req - 1; k >= 0; k--) begin
            if (elig[k]) lo_win = pw'(k);
            if (elig[k] && pw'(k) > ptr) begin
                hi_win   = pw'(k);
                hi_found = 1'b1;
            end
        end
        win         = mode ? lo_win : (hi_found ? hi_win : lo_win);
        onehot      = '0;
        onehot[win] = grant;
        level_nxt   = level + lw'(grant) - lw'(pop_en);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt         <= '0;
            push_en     <= 1'b0;
            fifo_din    <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            ovf_err     <= 1'b0;
            ptr         <= pw'(n_req - 1);
        end else begin
            gnt     <= onehot;
            push_en <= grant;
            if (grant) begin
                fifo_din <= req_data[int'(win)*fifo_w +: fifo_w];
                ptr      <= win;
            end
            level       <= level_nxt;
            almost_full <= level_nxt >= lw'(af_thresh);
            ovf_err     <= ovf_err | (push_en & fifo_full);
        end
    end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed bench with a grant/data scoreboard and a behavioural FIFO occupancy model.
module tb_fifo_push_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode = 1'b0;
    logic [3:0]   req = 4'b1111;
    logic [127:0] req_data = {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1};
    logic [3:0]   gnt;
    logic         push_en, pop_en, rd_req = 1'b0;
    logic [31:0]  fifo_din;
    logic         fifo_full, fifo_empty, almost_full, ovf_err;
    logic [3:0]   level;
    logic         force_full = 1'b0;
    int           cnt;
    int           passed = 0, failed = 0, total = 0;
    typedef struct {logic [3:0] g; logic [31:0] d;} exp_t;
    exp_t sb[$];
    fifo_push_arbiter dut (
        .clk(clk), .rst(rst), .mode(mode), .req(req), .req_data(req_data),
        .gnt(gnt), .push_en(push_en), .fifo_din(fifo_din), .rd_req(rd_req),
        .pop_en(pop_en), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .level(level), .almost_full(almost_full), .ovf_err(ovf_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk or posedge rst)
        if (rst) cnt <= 0;
        else cnt <= cnt + int'(push_en) - int'(pop_en);
    assign fifo_full  = (cnt == 8) | force_full;
    assign fifo_empty = cnt == 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_push(input logic [3:0] g, input logic [31:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sb.push_back(e);
    endtask
    task automatic tick_chk();
        exp_t e;
        tick();
        if (push_en === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_push", 32'(push_en), 32'd0);
            else begin
                e = sb.pop_front();
                chk("gnt", 32'(gnt), 32'(e.g));
                chk("fifo_din", fifo_din, e.d);
            end
        end else chk("gnt_idle", 32'(gnt), 32'd0);
    endtask
    initial begin
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_push_en", 32'(push_en), 0);
        chk("rst_fifo_din", fifo_din, 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_ovf_err", 32'(ovf_err), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) expect_push(4'b0001 << (i % 4), req_data[(i % 4)*32 +: 32]);
        for (int i = 0; i < 8; i++) begin
            tick_chk();
            chk("fill_push_en", 32'(push_en), 1);
            chk("fill_level", 32'(level), 32'(i + 1));
            chk("fill_almost_full", 32'(almost_full), 32'(i + 1 >= 6));
        end
        tick_chk();
        chk("full_level", 32'(level), 8);
        chk("full_din_hold", fifo_din, 32'hD4D4D4D4);
        sb_empty: chk("sb_fill", 32'(sb.size()), 0);
        rd_req = 1'b1;
        #1;
        chk("pop_en_full", 32'(pop_en), 1);
        tick_chk();
        chk("pop_at_full_level", 32'(level), 7);
        rd_req = 1'b0;
        expect_push(4'b0001, 32'hA1A1A1A1);
        tick_chk();
        chk("regrant_level", 32'(level), 8);
        tick_chk();
        chk("one_regrant_level", 32'(level), 8);
        chk("almost_full_hold", 32'(almost_full), 1);
        rd_req = 1'b1;
        tick_chk();
        chk("pop_level7", 32'(level), 7);
        expect_push(4'b0010, 32'hB2B2B2B2);
        tick_chk();
        chk("grant_pop_level", 32'(level), 7);
        rd_req = 1'b0;
        expect_push(4'b0100, 32'hC3C3C3C3);
        tick_chk();
        chk("refill_level", 32'(level), 8);
        tick_chk();
        chk("refill_stop_level", 32'(level), 8);
        chk("sb_simul", 32'(sb.size()), 0);
        req    = 4'b0000;
        rd_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick_chk();
            chk("drain_level", 32'(level), 32'(8 - k));
            chk("drain_almost_full", 32'(almost_full), 32'(8 - k >= 6));
        end
        chk("empty_pop_en", 32'(pop_en), 0);
        tick_chk();
        chk("empty_level", 32'(level), 0);
        rd_req = 1'b0;
        req    = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) expect_push(4'b0001, 32'hA1A1A1A1);
            tick_chk();
            chk("single_push_en", 32'(push_en), 32'(i % 2 == 0));
            chk("single_level", 32'(level), 32'(i / 2 + 1));
        end
        force_full = 1'b1;
        tick_chk();
        chk("ovf_set", 32'(ovf_err), 1);
        chk("ovf_level", 32'(level), 4);
        force_full = 1'b0;
        req        = 4'b0000;
        rd_req     = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick_chk();
            chk("drain2_level", 32'(level), 32'(4 - k));
        end
        chk("ovf_sticky", 32'(ovf_err), 1);
        chk("sb_single", 32'(sb.size()), 0);
        rd_req = 1'b0;
        mode   = 1'b1;
        req    = 4'b0101;
        for (int i = 0; i < 4; i++) expect_push(i % 2 == 0 ? 4'b0001 : 4'b0100, i % 2 == 0 ? 32'hA1A1A1A1 : 32'hC3C3C3C3);
        for (int i = 0; i < 4; i++) begin
            tick_chk();
            chk("fixed_level", 32'(level), 32'(i + 1));
        end
        #3;
        rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_push_en", 32'(push_en), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_fifo_din", fifo_din, 0);
        chk("arst_ovf_err", 32'(ovf_err), 0);
        chk("sb_final", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin (or fixed-priority) arbiter that shares the push port of one synchronous FIFO (fifo_w x fifo_d, push_en/pop_en/full/empty interface) among n_req producers.
- Keeps a reservation counter so a push is never issued into a full FIFO.
- Gates the consumer's read request into pop_en.
- Sits directly in front of the FIFO instance, between the producers and the FIFO.

Parameters:
- fifo_w, 32, data width of each requester and of the FIFO.
- fifo_d, 8, FIFO depth in entries.
- n_req, 4, number of producers (2..8).
- af_thresh, 6, level at or above which almost_full asserts (1..fifo_d).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- req  input  n_req  per-producer request; data must be held valid while req is high
- req_data  input  n_req*fifo_w  producer data; producer i uses bits [i*fifo_w +: fifo_w]
- gnt  output  n_req  one-hot, one-cycle grant pulse, registered
- push_en  output  1  registered FIFO push strobe
- fifo_din  output  fifo_w  registered FIFO write data
- rd_req  input  1  consumer read request
- pop_en  output  1  combinational: rd_req & ~fifo_empty
- fifo_full  input  1  FIFO full flag
- fifo_empty  input  1  FIFO empty flag
- level  output  clog2(fifo_d+1)  reserved plus stored entries (4 bits at default)
- almost_full  output  1  registered: level >= af_thresh
- ovf_err  output  1  sticky: set when push_en & fifo_full are both high at a clock edge

Behaviour:
- Reset (async, immediate):
  - gnt=0, push_en=0, fifo_din=0, level=0, almost_full=0, ovf_err=0.
  - Round-robin pointer = n_req-1, so requester 0 has first priority.
- Eligibility: requester i is eligible when req[i]=1 and gnt[i]=0 in the current cycle.
  - The gnt mask prevents a double grant while the producer reacts to its grant.
  - Consequence: one producer alone pushes at most every other cycle.
  - Two or more producers together can push every cycle.
- Grant condition: at least one requester is eligible and level < fifo_d, using the current registered level.
  - A pop in the same cycle does not unblock a grant when level = fifo_d.
- On a grant edge:
  - gnt <= onehot(winner).
  - push_en <= 1.
  - fifo_din <= data of the winner.
  - The FIFO writes at the following edge.
- With no grant: gnt <= 0, push_en <= 0, fifo_din holds its value.
- Winner selection:
  - mode=0: first eligible index scanning upward from pointer+1, wrapping n_req-1 -> 0. The pointer updates to the winner on each grant only.
  - mode=1: lowest eligible index. The pointer still tracks the last winner.
  - mode may change on any cycle and takes effect at the next decision.
- Level update:
  - level <= level + grant - (pop_en ? 1 : 0).
  - A grant and a pop on the same edge leave level unchanged.
  - Invariant: FIFO occupancy <= level <= fifo_d, so the FIFO cannot overflow.
  - Level never underflows because pop_en requires ~fifo_empty.
- Latency:
  - req -> gnt/push_en: 1 cycle.
  - push_en -> data stored in the FIFO: 1 further edge.
- ovf_err: set only by a protocol violation (for example, an external writer). Cleared only by rst.
- Reset mid-operation: any in-flight push_en is dropped immediately. The FIFO is reset by the same rst.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, push_en=0, fifo_din=0, level=0, almost_full=0; the first grant after release goes to requester 0.
- Single producer: req[0] held, data 32'hA1A1A1A1 -> gnt[0] and push_en pulse on alternating cycles, fifo_din=A1A1A1A1, level increments by 1 on every grant edge.
- Round-robin fairness: mode=0, req=4'b1111, datas A1../B2../C3../D4.. -> grants 0,1,2,3,0,... back-to-back, push_en high continuously; fill stops after 8 grants with level=8 and no further gnt.
- Full/almost_full: almost_full asserts when level becomes 6 and gnt stops at level 8. One cycle of rd_req then gives pop_en=1 and level=7, and exactly one new grant follows.
- Simultaneous events:
  - At level 7, a grant and a pop on the same edge -> level stays 7.
  - At level 8, a pop with req held -> no grant that cycle, grant on the next cycle.
  - rd_req with fifo_empty=1 -> pop_en=0, level unchanged.
- Fixed priority and async reset: mode=1, req[0] and req[2] held -> grant order 0,2,0,2. Asserting rst mid-burst (between clock edges) -> gnt, push_en and level clear before the next edge.
